scoreboard: RTL

- In-order issue / out-of-order write-back / in-order commit tracker for the execute pipeline.
- Holds `scoreboard_entry` records in a circular buffer.
- Allocates one entry per decoded instruction and accepts results from functional units by transaction ID.
- Presents the oldest completed entry to commit, publishes pending-destination (clobber) information, and optionally forwards results to the issue stage.

---
 rtl/scoreboard_pkg.sv | 50 +++++
 rtl/scoreboard.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types for the execute-pipeline scoreboard.
//   NR_SB_ENTRIES    : default number of scoreboard slots
//   trans_id_t       : slot index / transaction ID type
//   fu_t, exception, scoreboard_entry : per-instruction record types
//   rd_onehot()      : destination-register one-hot with x0 masked off
package scoreboard_pkg;

    localparam int NR_SB_ENTRIES    = 8;
    localparam int SB_TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef logic [SB_TRANS_ID_BITS-1:0] trans_id_t;

    typedef enum logic [2:0] {
        FU_NONE,
        FU_ALU,
        FU_BRANCH,
        FU_LOAD,
        FU_STORE,
        FU_MULT,
        FU_CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0] pc;
        fu_t         fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;      // result written back
        logic        in_flight;  // slot allocated, not yet retired
        exception    ex;
    } scoreboard_entry;

    // x0 is hard-wired zero, so it never counts as a pending destination.
    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        logic [31:0] oh;
        oh    = 32'b1 << rd;
        oh[0] = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// In-order issue / out-of-order write-back / in-order commit tracker.
// Entries live in a circular buffer indexed by transaction ID.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   flush_i               drop every entry (beats alloc / wb / commit)
//   full_o                all NR_ENTRIES slots occupied
//   decoded_instr_*       allocation request / record / accept
//   trans_id_o            slot the current allocation lands in
//   rd_clobber_o          destinations of all in-flight entries (x0 masked)
//   rs1_i/rs2_i, rsX_*_o  operand forwarding lookup
//   wb_*                  functional-unit result by transaction ID
//   commit_*              oldest entry, its completion flag, retire ack
// Optional feature macro: SB_FORWARD_EN enables operand forwarding;
// without it rsX_valid_o / rsX_o are tied to zero.
module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NR_ENTRIES    = NR_SB_ENTRIES,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    input  scoreboard_entry          decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     decoded_instr_ack_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic [31:0]              rd_clobber_o,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     rs1_valid_o,
    output logic                     rs2_valid_o,
    output logic [63:0]              rs1_o,
    output logic [63:0]              rs2_o,
    input  logic                     wb_valid_i,
    input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i,
    input  logic [63:0]              wb_data_i,
    input  exception                 wb_ex_i,
    output scoreboard_entry          commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i
);

    typedef logic [TRANS_ID_BITS-1:0] ptr_t;
    typedef logic [TRANS_ID_BITS:0]   cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(NR_ENTRIES);

    scoreboard_entry mem_q [NR_ENTRIES];
    scoreboard_entry mem_d [NR_ENTRIES];
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    cnt_t            cnt_q, cnt_d;
    logic            commit_fire;
    logic [31:0]     clobber;

    // Full is judged on the registered count, so a same-cycle commit
    // never frees a slot for a same-cycle allocation.
    assign full_o              = (cnt_q == FULL_CNT);
    assign decoded_instr_ack_o = decoded_instr_valid_i & ~full_o;
    assign trans_id_o          = tail_q;
    assign commit_instr_o      = mem_q[head_q];
    assign commit_valid_o      = (cnt_q != '0) & mem_q[head_q].valid;
    assign commit_fire         = commit_ack_i & commit_valid_o;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_d[i] = '0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            // Late results for retired/flushed slots are dropped.
            if (wb_valid_i && mem_q[wb_trans_id_i].in_flight) begin
                mem_d[wb_trans_id_i].result = wb_data_i;
                mem_d[wb_trans_id_i].ex     = wb_ex_i;
                mem_d[wb_trans_id_i].valid  = 1'b1;
            end
            // Tail slot is never in flight while not full, so it cannot
            // collide with the write-back above.
            if (decoded_instr_ack_o) begin
                mem_d[tail_q]           = decoded_instr_i;
                mem_d[tail_q].valid     = 1'b0;
                mem_d[tail_q].in_flight = 1'b1;
                mem_d[tail_q].ex.valid  = 1'b0;
                tail_d                  = tail_q + ptr_t'(1);
            end
            if (commit_fire) begin
                mem_d[head_q] = '0;
                head_d        = head_q + ptr_t'(1);
            end
            case ({decoded_instr_ack_o, commit_fire})
                2'b10:   cnt_d = cnt_q + cnt_t'(1);
                2'b01:   cnt_d = cnt_q - cnt_t'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

    always_comb begin
        clobber = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (mem_q[i].in_flight) begin
                clobber = clobber | rd_onehot(mem_q[i].rd);
            end
        end
    end
    assign rd_clobber_o = clobber;

`ifdef SB_FORWARD_EN
    logic [1:0]       fwd_vld;
    logic [1:0][63:0] fwd_data;
    logic [1:0][4:0]  fwd_rs;
    ptr_t             idx;

    assign fwd_rs = {rs2_i, rs1_i};

    // Walk from tail (oldest possible slot) toward tail-1 (youngest);
    // later hits overwrite earlier ones so the youngest match wins even
    // when an older match already holds a valid result.
    always_comb begin
        fwd_vld  = '0;
        fwd_data = '0;
        idx      = '0;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                idx = tail_q + ptr_t'(i);
                if (mem_q[idx].in_flight && (fwd_rs[op] != 5'd0) &&
                    (mem_q[idx].rd == fwd_rs[op])) begin
                    fwd_vld[op]  = mem_q[idx].valid;
                    fwd_data[op] = mem_q[idx].result;
                end
            end
        end
    end

    assign rs1_valid_o = fwd_vld[0];
    assign rs2_valid_o = fwd_vld[1];
    assign rs1_o       = fwd_data[0];
    assign rs2_o       = fwd_data[1];
`else
    logic unused_rs;
    assign unused_rs   = ^{rs1_i, rs2_i};
    assign rs1_valid_o = 1'b0;
    assign rs2_valid_o = 1'b0;
    assign rs1_o       = '0;
    assign rs2_o       = '0;
`endif

endmodule
